id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register of the 5-stage MIPS core, directly downstream of control_unit.
//  Latches the 12-bit decoded control bundle plus ID-stage operands for the EX stage.
//  Contains load-use hazard detection: freezes PC/IF-ID via stall and injects a bubble.
//  Honours a flush from the taken-branch/jump resolution logic.
// PARAMETERS
//  DATA_W      32  operand / PC width
//  REG_ADDR_W  5   register specifier width
//  CTRL_W      12  control bundle width
//  CNT_W       16  bubble counter width (only with ID_EX_BUBBLE_CNT_EN)
// PORTS
//  clk           in   1           rising-edge clock
//  rst           in   1           synchronous, active-high reset
//  ctrl_in       in   CTRL_W      control_signal from control_unit
//  valid_in      in   1           ID holds a real instruction
//  flush         in   1           kill instruction entering EX (taken branch/jump)
//  pc_plus4_in   in   DATA_W      PC+4 of ID instruction
//  rs_data_in    in   DATA_W      register-file read port A
//  rt_data_in    in   DATA_W      register-file read port B
//  imm_in        in   DATA_W      sign-extended immediate
//  rs_in/rt_in/rd_in  in  REG_ADDR_W  specifiers from instr[25:21]/[20:16]/[15:11]
//  ctrl_out, valid_out, pc_plus4_out, rs_data_out, rt_data_out, imm_out,
//  rs_out, rt_out, rd_out   out  (widths as inputs)  registered EX-stage copies
//  stall         out  1           hold PC and IF/ID this cycle (combinational)
//  bubble_cnt    out  CNT_W       bubbles inserted (only with ID_EX_BUBBLE_CNT_EN)
// BEHAVIOUR
//  Control bundle bit map: [11:10] regdst, [9] jump, [8] branch, [7] memread,
//   [6:5] memtoreg, [4:3] aluop, [2] memwrite, [1] alusrc, [0] regwrite.
//  Reset: every registered output 0 (ctrl_out=12'h000, valid_out=0, all data/specifiers 0).
//  Latency: 1 cycle; inputs at edge N appear at outputs after edge N.
//  uses_rt = (ctrl_in[11:10]==2'b01) | ctrl_in[8] | ctrl_in[2]  (R-type, beq, sw).
//  hazard = valid_out & ctrl_out[7] & (rt_out!=0) & valid_in &
//           ((rt_out==rs_in) | (uses_rt & (rt_out==rt_in))).
//  stall = hazard & ~flush & ~rst.
//  Per-edge priority: rst > flush > hazard > load.
//   - rst: clear as above.
//   - flush: load bubble (ctrl_out=0, valid_out=0, data/specifiers=0); stall is 0.
//   - hazard: load bubble; upstream holds, so same ID instruction re-presented next cycle.
//   - otherwise: load all inputs; valid_out=valid_in.
//  Bubble zeroes memread, so a load-use stall lasts exactly one cycle.
//  valid_in=0 loads normally, but ctrl_out is forced to 0 so EX never writes or accesses memory.
//  lw writing $0 never stalls. Back-to-back lw chains stall once per dependent pair.
//  No internal FSM beyond the pipeline register; no multi-cycle state survives a flush.
// CONFIGURATION
//  ID_EX_BUBBLE_CNT_EN defined:
//   - bubble_cnt port exists; +1 on each hazard-injected bubble (not on flush); saturates at all-ones.
//   - Cleared by rst.
//  Undefined: port and counter absent; all other behaviour identical.
// TESTING
//  rst high 2 cycles with random inputs -> all outputs 0, stall 0.
//  lw $t0 (ctrl 12'h0AB, rt=8) then add rs=8 -> stall=1 one cycle, ctrl_out=0 next edge, add issues one cycle later.
//  lw rt=0 followed by add rs=0 -> stall stays 0, no bubble.
//  lw rt=8 then addi rs=9, rt=8 (uses_rt=0) -> no stall. Same with sw rt=8 -> stall.
//  hazard and flush in same cycle -> stall=0, valid_out=0, bubble_cnt unchanged.
//  ID_EX_BUBBLE_CNT_EN, CNT_W=2, 5 hazards -> bubble_cnt=3 (saturated). rst mid-stall -> bubble_cnt=0, stall=0.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage
//   ID/EX pipeline register of the 5-stage MIPS core. It captures the 12-bit
//   control bundle from control_unit together with the ID-stage operands and
//   register specifiers. It also detects load-use hazards: when one is found it
//   raises stall so the PC and IF/ID hold, and it loads a bubble into EX. A flush
//   from branch/jump resolution kills the instruction that would enter EX.
//
//   Ports
//     clk, rst            rising-edge clock, synchronous active-high reset
//     ctrl_in, valid_in   control bundle and valid flag of the ID instruction
//     flush               kill the instruction entering EX
//     pc_plus4_in, rs_data_in, rt_data_in, imm_in   ID-stage operands
//     rs_in, rt_in, rd_in register specifiers
//     *_out               registered EX-stage copies of the above
//     stall               combinational hold request for PC and IF/ID
//     bubble_cnt          saturating count of hazard bubbles
//                         (present only when ID_EX_BUBBLE_CNT_EN is defined)
//
//   Control bundle: [11:10] regdst, [9] jump, [8] branch, [7] memread,
//                   [6:5] memtoreg, [4:3] aluop, [2] memwrite, [1] alusrc,
//                   [0] regwrite.
//
//   Build option: ID_EX_BUBBLE_CNT_EN adds the bubble counter and its port.
module id_ex_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CTRL_W     = 12,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CTRL_W-1:0]     ctrl_in,
  input  logic                  valid_in,
  input  logic                  flush,
  input  logic [DATA_W-1:0]     pc_plus4_in,
  input  logic [DATA_W-1:0]     rs_data_in,
  input  logic [DATA_W-1:0]     rt_data_in,
  input  logic [DATA_W-1:0]     imm_in,
  input  logic [REG_ADDR_W-1:0] rs_in,
  input  logic [REG_ADDR_W-1:0] rt_in,
  input  logic [REG_ADDR_W-1:0] rd_in,
  output logic [CTRL_W-1:0]     ctrl_out,
  output logic                  valid_out,
  output logic [DATA_W-1:0]     pc_plus4_out,
  output logic [DATA_W-1:0]     rs_data_out,
  output logic [DATA_W-1:0]     rt_data_out,
  output logic [DATA_W-1:0]     imm_out,
  output logic [REG_ADDR_W-1:0] rs_out,
  output logic [REG_ADDR_W-1:0] rt_out,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic                  stall
`ifdef ID_EX_BUBBLE_CNT_EN
  ,
  output logic [CNT_W-1:0]      bubble_cnt
`endif
);

  logic [CTRL_W-1:0]     ctrl_q, ctrl_d;
  logic                  valid_q, valid_d;
  logic [DATA_W-1:0]     pc_plus4_q, pc_plus4_d;
  logic [DATA_W-1:0]     rs_data_q, rs_data_d;
  logic [DATA_W-1:0]     rt_data_q, rt_data_d;
  logic [DATA_W-1:0]     imm_q, imm_d;
  logic [REG_ADDR_W-1:0] rs_q, rs_d;
  logic [REG_ADDR_W-1:0] rt_q, rt_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;

  logic uses_rt;
  logic hazard;
  logic bubble;

  // The ID instruction reads rt as a source for R-type, branch and store.
  assign uses_rt = (ctrl_in[11:10] == 2'b01) | ctrl_in[8] | ctrl_in[2];

  // A load in EX whose destination (rt) feeds the ID instruction. A load to $0
  // never creates a dependency.
  assign hazard = valid_q & ctrl_q[7] & (rt_q != '0) & valid_in &
                  ((rt_q == rs_in) | (uses_rt & (rt_q == rt_in)));

  assign stall  = hazard & ~flush & ~rst;
  assign bubble = flush | hazard;

  always_comb begin
    ctrl_d     = valid_in ? ctrl_in : '0;
    valid_d    = valid_in;
    pc_plus4_d = pc_plus4_in;
    rs_data_d  = rs_data_in;
    rt_data_d  = rt_data_in;
    imm_d      = imm_in;
    rs_d       = rs_in;
    rt_d       = rt_in;
    rd_d       = rd_in;
    if (bubble) begin
      ctrl_d     = '0;
      valid_d    = 1'b0;
      pc_plus4_d = '0;
      rs_data_d  = '0;
      rt_data_d  = '0;
      imm_d      = '0;
      rs_d       = '0;
      rt_d       = '0;
      rd_d       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q     <= '0;
      valid_q    <= 1'b0;
      pc_plus4_q <= '0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_q      <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      valid_q    <= valid_d;
      pc_plus4_q <= pc_plus4_d;
      rs_data_q  <= rs_data_d;
      rt_data_q  <= rt_data_d;
      imm_q      <= imm_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      rd_q       <= rd_d;
    end
  end

  assign ctrl_out     = ctrl_q;
  assign valid_out    = valid_q;
  assign pc_plus4_out = pc_plus4_q;
  assign rs_data_out  = rs_data_q;
  assign rt_data_out  = rt_data_q;
  assign imm_out      = imm_q;
  assign rs_out       = rs_q;
  assign rt_out       = rt_q;
  assign rd_out       = rd_q;

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts only hazard bubbles; a flush in the same cycle takes precedence.
  always_comb begin
    cnt_d = cnt_q;
    if (hazard && !flush && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign bubble_cnt = cnt_q;
`else
  // Keeps CNT_W referenced when the counter is not built.
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  localparam int CNT_W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] ctrl_in;
  logic        valid_in;
  logic        flush;
  logic [31:0] pc_plus4_in, rs_data_in, rt_data_in, imm_in;
  logic [4:0]  rs_in, rt_in, rd_in;
  logic [11:0] ctrl_out;
  logic        valid_out;
  logic [31:0] pc_plus4_out, rs_data_out, rt_data_out, imm_out;
  logic [4:0]  rs_out, rt_out, rd_out;
  logic        stall;
`ifdef ID_EX_BUBBLE_CNT_EN
  logic [CNT_W-1:0] bubble_cnt;
`endif

  always #5 clk = ~clk;

  id_ex_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .ctrl_in(ctrl_in), .valid_in(valid_in), .flush(flush),
    .pc_plus4_in(pc_plus4_in), .rs_data_in(rs_data_in), .rt_data_in(rt_data_in),
    .imm_in(imm_in), .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in),
    .ctrl_out(ctrl_out), .valid_out(valid_out), .pc_plus4_out(pc_plus4_out),
    .rs_data_out(rs_data_out), .rt_data_out(rt_data_out), .imm_out(imm_out),
    .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out), .stall(stall)
`ifdef ID_EX_BUBBLE_CNT_EN
    , .bubble_cnt(bubble_cnt)
`endif
  );

  typedef struct {
    int          idx;
    logic [11:0] ctrl;
    logic        valid;
    logic [31:0] pc, rsd, rtd, imm;
    logic [4:0]  rs, rt, rd;
    int          cnt;
  } exp_t;

  exp_t out_q[$];
  bit   stall_q[$];
  int   checks = 0;
  int   failures = 0;
  int   n = 0;

  localparam logic [11:0] LW   = 12'h0AB;
  localparam logic [11:0] ADD  = 12'h411;
  localparam logic [11:0] ADDI = 12'h003;
  localparam logic [11:0] SW   = 12'h006;
  localparam logic [11:0] BEQ  = 12'h108;

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d actual=%h expected=%h", nm, idx, act, exp);
    end
  endtask

  // One ID-stage cycle: drive inputs and queue the hand-computed response.
  // bub=1 means the data/specifier outputs must be zero after the edge.
  task automatic vec(input bit r, input bit f, input bit v, input logic [11:0] c,
                     input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                     input bit e_stall, input bit bub, input logic [11:0] e_ctrl,
                     input bit e_valid, input int e_cnt);
    exp_t e;
    @(negedge clk);
    rst = r;
    if (r) begin
      flush       = 1'($urandom);
      valid_in    = 1'($urandom);
      ctrl_in     = 12'($urandom);
      pc_plus4_in = $urandom; rs_data_in = $urandom;
      rt_data_in  = $urandom; imm_in = $urandom;
      rs_in = 5'($urandom); rt_in = 5'($urandom); rd_in = 5'($urandom);
    end else begin
      flush = f; valid_in = v; ctrl_in = c;
      rs_in = s; rt_in = t; rd_in = d;
      pc_plus4_in = 32'h0000_1000 + 32'(4 * n);
      rs_data_in  = 32'hA000_0000 + 32'(n);
      rt_data_in  = 32'hB000_0000 + 32'(n);
      imm_in      = 32'hC000_0000 + 32'(n);
    end
    e.idx = n; e.ctrl = e_ctrl; e.valid = e_valid; e.cnt = e_cnt;
    e.pc  = bub ? 32'h0 : pc_plus4_in;
    e.rsd = bub ? 32'h0 : rs_data_in;
    e.rtd = bub ? 32'h0 : rt_data_in;
    e.imm = bub ? 32'h0 : imm_in;
    e.rs  = bub ? 5'd0 : rs_in;
    e.rt  = bub ? 5'd0 : rt_in;
    e.rd  = bub ? 5'd0 : rd_in;
    stall_q.push_back(e_stall);
    out_q.push_back(e);
    n++;
  endtask

  // Stall monitor: combinational output, sampled mid-cycle.
  int stall_idx = 0;
  initial forever begin
    @(negedge clk);
    #3;
    if (stall_q.size() != 0) begin
      chk("stall", stall_idx, {31'd0, stall}, {31'd0, stall_q.pop_front()});
      stall_idx++;
    end
  end

  // Output monitor: registered outputs, sampled just after the edge.
  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (out_q.size() != 0) begin
      e = out_q.pop_front();
      chk("ctrl_out", e.idx, {20'd0, ctrl_out}, {20'd0, e.ctrl});
      chk("valid_out", e.idx, {31'd0, valid_out}, {31'd0, e.valid});
      chk("pc_plus4_out", e.idx, pc_plus4_out, e.pc);
      chk("rs_data_out", e.idx, rs_data_out, e.rsd);
      chk("rt_data_out", e.idx, rt_data_out, e.rtd);
      chk("imm_out", e.idx, imm_out, e.imm);
      chk("rs_out", e.idx, {27'd0, rs_out}, {27'd0, e.rs});
      chk("rt_out", e.idx, {27'd0, rt_out}, {27'd0, e.rt});
      chk("rd_out", e.idx, {27'd0, rd_out}, {27'd0, e.rd});
`ifdef ID_EX_BUBBLE_CNT_EN
      chk("bubble_cnt", e.idx, {30'd0, bubble_cnt}, 32'(e.cnt));
`endif
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; valid_in = 1'b0; ctrl_in = '0;
    pc_plus4_in = '0; rs_data_in = '0; rt_data_in = '0; imm_in = '0;
    rs_in = '0; rt_in = '0; rd_in = '0;
    //   rst f v ctrl  rs rt rd  stall bub e_ctrl v  cnt
    vec(1, 0, 0, 0,    0, 0, 0,  0,    1,  12'h0, 0, 0);  // reset, random inputs
    vec(1, 0, 0, 0,    0, 0, 0,  0,    1,  12'h0, 0, 0);
    vec(0, 0, 1, LW,   2, 8, 0,  0,    0,  LW,    1, 0);  // lw $8
    vec(0, 0, 1, ADD,  8, 9, 10, 1,    1,  12'h0, 0, 1);  // add rs=8 -> stall
    vec(0, 0, 1, ADD,  8, 9, 10, 0,    0,  ADD,   1, 1);  // re-presented, issues
    vec(0, 0, 1, LW,   1, 0, 0,  0,    0,  LW,    1, 1);  // lw $0
    vec(0, 0, 1, ADD,  0, 3, 4,  0,    0,  ADD,   1, 1);  // no stall on $0
    vec(0, 0, 1, LW,   1, 8, 0,  0,    0,  LW,    1, 1);
    vec(0, 0, 1, ADDI, 9, 8, 0,  0,    0,  ADDI,  1, 1);  // rt not a source
    vec(0, 0, 1, LW,   1, 8, 0,  0,    0,  LW,    1, 1);
    vec(0, 0, 1, SW,   9, 8, 0,  1,    1,  12'h0, 0, 2);  // sw uses rt -> stall
    vec(0, 0, 1, SW,   9, 8, 0,  0,    0,  SW,    1, 2);
    vec(0, 0, 1, LW,   1, 8, 0,  0,    0,  LW,    1, 2);
    vec(0, 1, 1, BEQ,  3, 8, 0,  0,    1,  12'h0, 0, 2);  // hazard + flush
    vec(0, 0, 1, LW,   1, 5, 0,  0,    0,  LW,    1, 2);
    vec(0, 0, 1, LW,   5, 6, 0,  1,    1,  12'h0, 0, 3);  // lw chain
    vec(0, 0, 1, LW,   5, 6, 0,  0,    0,  LW,    1, 3);
    vec(0, 0, 1, ADD,  6, 7, 8,  1,    1,  12'h0, 0, 3);  // 4th hazard, saturated
    vec(0, 0, 1, ADD,  6, 7, 8,  0,    0,  ADD,   1, 3);
    vec(0, 0, 1, LW,   1, 8, 0,  0,    0,  LW,    1, 3);
    vec(0, 0, 1, ADD,  8, 9, 10, 1,    1,  12'h0, 0, 3);  // 5th hazard
    vec(0, 0, 0, LW,   3, 4, 5,  0,    0,  12'h0, 0, 3);  // invalid: ctrl forced 0
    vec(0, 0, 1, LW,   1, 8, 0,  0,    0,  LW,    1, 3);
    vec(0, 0, 0, ADD,  8, 9, 10, 0,    0,  12'h0, 0, 3);  // invalid ID: no stall
    vec(0, 0, 1, LW,   1, 8, 0,  0,    0,  LW,    1, 3);
    vec(1, 0, 0, 0,    0, 0, 0,  0,    1,  12'h0, 0, 0);  // rst during hazard
    vec(0, 0, 1, ADD,  8, 9, 10, 0,    0,  ADD,   1, 0);
    vec(0, 1, 1, ADD,  1, 2, 3,  0,    1,  12'h0, 0, 0);  // plain flush
    repeat (3) @(negedge clk);
    chk("queues_drained", -1, 32'(out_q.size() + stall_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
